// File: rtl/k005290_tile_shifter_pkg.sv
// Shared constants and helpers for the K005290 tilemap pixel shifter path.
// Holds the pixel/palette geometry, the fetch phases and the nibble-order helper.
package k005290_tile_shifter_pkg;

    localparam int PX_W           = 4;
    localparam int PAL_W          = 7;
    localparam int ATTR_HFLIP_BIT = 7;
    localparam int LINE_PX        = 8;
    localparam int LINE_W         = LINE_PX * PX_W;

    localparam logic [2:0] PH_A_FETCH = 3'd3;
    localparam logic [2:0] PH_B_FETCH = 3'd7;

    // Reverses pixel order within a tile line; bit order inside each pixel is kept.
    function automatic logic [LINE_W-1:0] nibble_reverse(input logic [LINE_W-1:0] line);
        logic [LINE_W-1:0] rev;
        rev = '0;
        for (int i = 0; i < LINE_PX; i++) begin
            rev[i*PX_W +: PX_W] = line[(LINE_PX-1-i)*PX_W +: PX_W];
        end
        return rev;
    endfunction

endpackage

// File: rtl/k005290_layer_shifter.sv
// One tilemap layer: parallel-load pixel shifter, palette register and registered outputs.
// Shifts out one pixel per enabled cycle, MSB pixel first, zero-filling behind it.
module k005290_layer_shifter
    import k005290_tile_shifter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen_n,
    input  logic              load,
    input  logic [LINE_W-1:0] load_data,
    input  logic [PAL_W-1:0]  load_pal,
    output logic [PX_W-1:0]   px,
    output logic [PAL_W-1:0]  pal,
    output logic              opaque
);

    logic [LINE_W-1:0] shift_reg;
    logic [PAL_W-1:0]  pal_reg;
    logic [PX_W-1:0]   px_reg;
    logic [PAL_W-1:0]  pal_out_reg;
    logic              opaque_reg;
    logic [PX_W-1:0]   head_px;

    assign head_px = shift_reg[LINE_W-1 -: PX_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            pal_reg     <= '0;
            px_reg      <= '0;
            pal_out_reg <= '0;
            opaque_reg  <= 1'b0;
        end else if (!cen_n) begin
            // A load always beats the shift it coincides with.
            if (load) begin
                shift_reg <= load_data;
                pal_reg   <= load_pal;
            end else begin
                shift_reg <= {shift_reg[LINE_W-PX_W-1:0], {PX_W{1'b0}}};
            end
            px_reg      <= head_px;
            pal_out_reg <= pal_reg;
            opaque_reg  <= (head_px != '0);
        end
    end

    assign px     = px_reg;
    assign pal    = pal_out_reg;
    assign opaque = opaque_reg;

endmodule

// File: rtl/k005290_tile_shifter.sv
// Tile data consumer for TM-A and TM-B: stages fetched CHARRAM/attribute data,
// reloads the per-layer shifters on the generator strobes and serializes pixels.
module k005290_tile_shifter
    import k005290_tile_shifter_pkg::*;
(
    input  logic              i_EMU_MCLK,
    input  logic              i_EMU_RST_n,
    input  logic              i_EMU_CLK6MPCEN_n,
    input  logic              i_HFLIP,
    input  logic              i_ABS_4H,
    input  logic              i_ABS_2H,
    input  logic              i_ABS_1H,
    input  logic [LINE_W-1:0] i_CHARRAM_DATA,
    input  logic [7:0]        i_VRAM_ATTR,
    input  logic              i_SHIFTA1_n,
    input  logic              i_SHIFTA2_n,
    input  logic              i_SHIFTB_n,
    output logic [PX_W-1:0]   o_TMA_PX,
    output logic [PX_W-1:0]   o_TMB_PX,
    output logic [PAL_W-1:0]  o_TMA_PAL,
    output logic [PAL_W-1:0]  o_TMB_PAL,
    output logic              o_TMA_OPAQUE,
    output logic              o_TMB_OPAQUE
);

    logic [2:0]        phase;
    logic              eff_flip;
    logic [LINE_W-1:0] ordered_line;

    logic [LINE_W-1:0] a_stage_data_reg, b_stage_data_reg, a_hold_data_reg;
    logic [PAL_W-1:0]  a_stage_pal_reg,  b_stage_pal_reg,  a_hold_pal_reg;

    assign phase    = {i_ABS_4H, i_ABS_2H, i_ABS_1H};
    // Flip is resolved at capture time, so the shifters never need to know about it.
    assign eff_flip     = i_HFLIP ^ i_VRAM_ATTR[ATTR_HFLIP_BIT];
    assign ordered_line = eff_flip ? nibble_reverse(i_CHARRAM_DATA) : i_CHARRAM_DATA;

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            a_stage_data_reg <= '0;
            a_stage_pal_reg  <= '0;
            b_stage_data_reg <= '0;
            b_stage_pal_reg  <= '0;
            a_hold_data_reg  <= '0;
            a_hold_pal_reg   <= '0;
        end else if (!i_EMU_CLK6MPCEN_n) begin
            if (phase == PH_A_FETCH) begin
                a_stage_data_reg <= ordered_line;
                a_stage_pal_reg  <= i_VRAM_ATTR[PAL_W-1:0];
            end
            if (phase == PH_B_FETCH) begin
                b_stage_data_reg <= ordered_line;
                b_stage_pal_reg  <= i_VRAM_ATTR[PAL_W-1:0];
            end
            if (!i_SHIFTA2_n) begin
                a_hold_data_reg <= a_stage_data_reg;
                a_hold_pal_reg  <= a_stage_pal_reg;
            end
        end
    end

    // Layer 0 is TM-A (fed from holding), layer 1 is TM-B (fed straight from staging).
    logic              layer_load [2];
    logic [LINE_W-1:0] layer_data [2];
    logic [PAL_W-1:0]  layer_pal_in [2];
    logic [PX_W-1:0]   layer_px [2];
    logic [PAL_W-1:0]  layer_pal [2];
    logic              layer_opaque [2];

    assign layer_load[0]   = ~i_SHIFTA1_n;
    assign layer_data[0]   = a_hold_data_reg;
    assign layer_pal_in[0] = a_hold_pal_reg;
    assign layer_load[1]   = ~i_SHIFTB_n;
    assign layer_data[1]   = b_stage_data_reg;
    assign layer_pal_in[1] = b_stage_pal_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_layer
            k005290_layer_shifter u_layer (
                .clk       (i_EMU_MCLK),
                .rst_n     (i_EMU_RST_n),
                .cen_n     (i_EMU_CLK6MPCEN_n),
                .load      (layer_load[gi]),
                .load_data (layer_data[gi]),
                .load_pal  (layer_pal_in[gi]),
                .px        (layer_px[gi]),
                .pal       (layer_pal[gi]),
                .opaque    (layer_opaque[gi])
            );
        end
    endgenerate

    assign o_TMA_PX     = layer_px[0];
    assign o_TMA_PAL    = layer_pal[0];
    assign o_TMA_OPAQUE = layer_opaque[0];
    assign o_TMB_PX     = layer_px[1];
    assign o_TMB_PAL    = layer_pal[1];
    assign o_TMB_OPAQUE = layer_opaque[1];

endmodule
